// File: rtl/alu_slice_sequencer.sv
// alu_slice_sequencer: bit-serial driver/collector for one single-bit
// function-generator slice. It feeds A/B bits LSB first, samples the
// slice's propagate/generate returns, and assembles a W-bit result and carry.
module alu_slice_sequencer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic [3:0]   op_sel,
    input  logic         op_m,
    input  logic         op_cin,
    output logic         fg_a,
    output logic         fg_b,
    output logic [3:0]   fg_s,
    input  logic         fg_x,
    input  logic         fg_y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         zero
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [W-1:0]  a_sh;     // A shifted right each RUN cycle; bit 0 drives the slice
    logic [W-1:0]  b_sh;
    logic [W-1:0]  res_sh;   // result bits enter at the MSB and end up LSB-aligned
    logic [CW-1:0] cnt;
    logic          m_r;
    logic          carry;

    // Slice bits come straight from flops so they cannot glitch. After W
    // shifts with zero fill the operand registers are empty, which keeps
    // fg_a/fg_b at 0 outside RUN without any gating logic.
    assign fg_a   = a_sh[0];
    assign fg_b   = b_sh[0];
    assign result = res_sh;
    assign zero   = ~|res_sh;

    logic res_bit;
    logic carry_nx;

    // Per-bit combine of the slice returns with the running carry.
    always_comb begin
        res_bit  = m_r ? fg_x : (fg_x ^ carry);
        carry_nx = fg_y | (fg_x & carry);
    end

    // Sequencer FSM: accept, W slice cycles, hold result until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            fg_s      <= '0;
            m_r       <= 1'b0;
            carry     <= 1'b0;
            cnt       <= '0;
            res_sh    <= '0;
            cout      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= op_a;
                        b_sh     <= op_b;
                        fg_s     <= op_sel;
                        m_r      <= op_m;
                        carry    <= op_cin & ~op_m;
                        cnt      <= '0;
                        res_sh   <= '0;
                        cout     <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= {res_bit, res_sh[W-1:1]};
                    if (!m_r) carry <= carry_nx;
                    if (cnt == CW'(W - 1)) begin
                        // Last bit: counter parks here rather than wrapping.
                        state     <= DONE;
                        out_valid <= 1'b1;
                        fg_s      <= '0;
                        cout      <= ~m_r & carry_nx;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    // in_ready stays low here, so a new request can only be
                    // taken the cycle after the result is consumed.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Bench for alu_slice_sequencer: behavioural slice model, scoreboard of
// expected results pushed at accept and checked when the result is consumed.
module tb_alu_slice_sequencer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic [3:0]   op_sel = '0;
    logic         op_m = 1'b0;
    logic         op_cin = 1'b0;
    logic         fg_a, fg_b;
    logic [3:0]   fg_s;
    logic         fg_x, fg_y;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         cout;
    logic         zero;

    alu_slice_sequencer #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_sel(op_sel), .op_m(op_m), .op_cin(op_cin),
        .fg_a(fg_a), .fg_b(fg_b), .fg_s(fg_s), .fg_x(fg_x), .fg_y(fg_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .zero(zero)
    );

    always #5 clk = ~clk;

    // Slice model: adder cell for 1001, AND cell for 1011.
    always_comb begin
        fg_x = 1'b0;
        fg_y = 1'b0;
        case (fg_s)
            4'b1001: begin fg_x = fg_a ^ fg_b; fg_y = fg_a & fg_b; end
            4'b1011: begin fg_x = fg_a & fg_b; fg_y = 1'b0;        end
            default: ;
        endcase
    end

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         z;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [3:0] sel, input logic m, input logic cin);
        exp_t       e;
        logic [W:0] s;
        if (!m) begin
            s     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            e.res = s[W-1:0];
            e.c   = s[W];
        end else begin
            e.res = (sel == 4'b1011) ? (a & b) : (a ^ b);
            e.c   = 1'b0;
        end
        e.z = (e.res == '0);
        return e;
    endfunction

    // Scoreboard check on every result handshake.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            chk("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_result", result, e.res);
                chk("sb_cout", cout, e.c);
                chk("sb_zero", zero, e.z);
            end
        end
    end

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_vld"}, out_valid, 0);
        chk({tag, "_res"}, result, 0);
        chk({tag, "_cout"}, cout, 0);
        chk({tag, "_zero"}, zero, 1);
        chk({tag, "_fga"}, fg_a, 0);
        chk({tag, "_fgb"}, fg_b, 0);
        chk({tag, "_fgs"}, fg_s, 0);
    endtask

    // Accept one op and step through RUN. The accept edge plus W RUN edges
    // gives out_valid on the (W+1)th edge counted from the accept edge.
    // abort_k >= 0 pulls reset at that bit index instead of finishing.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] sel, input logic m, input logic cin,
                          input int abort_k);
        @(negedge clk);
        chk("idle_rdy", in_ready, 1);
        chk("idle_fgs", fg_s, 0);
        chk("idle_fga", fg_a, 0);
        op_a = a; op_b = b; op_sel = sel; op_m = m; op_cin = cin;
        in_valid = 1'b1;
        @(posedge clk);
        sb.push_back(model(a, b, sel, m, cin));
        #1;
        in_valid = 1'b0;
        op_a = W'($urandom); op_b = W'($urandom); op_sel = 4'($urandom);
        op_m = 1'($urandom); op_cin = 1'($urandom);
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            if (k == abort_k) begin
                rst_n = 1'b0;
                #1;
                chk_reset_outs("rst_mid");
                void'(sb.pop_back());
                @(negedge clk);
                rst_n = 1'b1;
                #1;
                chk("rst_rdy", in_ready, 1);
                return;
            end
            chk("run_fga", fg_a, a[k]);
            chk("run_fgb", fg_b, b[k]);
            chk("run_fgs", fg_s, sel);
            chk("run_vld", out_valid, 0);
            chk("run_rdy", in_ready, 0);
            @(posedge clk);
        end
        @(negedge clk);
        chk("lat_vld", out_valid, 1);
        chk("done_fgs", fg_s, 0);
        chk("done_fga", fg_a, 0);
    endtask

    // Consume the result after `hold` cycles of backpressure; optionally
    // pulse a request during the hold, which must be ignored.
    task automatic finish_op(input int hold, input logic poke);
        logic [W-1:0] exp_res;
        exp_res = (sb.size() > 0) ? sb[0].res : '0;
        if (!out_ready) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("bp_vld", out_valid, 1);
                chk("bp_rdy", in_ready, 0);
                chk("bp_res", result, exp_res);
                if (poke && i == 1) begin
                    in_valid = 1'b1; op_a = 16'h7777; op_b = 16'h1111; op_sel = 4'b1001;
                end
                if (poke && i == 3) in_valid = 1'b0;
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
            @(negedge clk);
            chk("pre_rdy", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("post_rdy", in_ready, 1);
        chk("post_vld", out_valid, 0);
    endtask

    initial begin
        // Reset values while asserted and right after release.
        #12;
        chk_reset_outs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_rdy0", in_ready, 1);

        // Directed adds and overflow corners.
        run_op(16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b0, -1); finish_op(0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, -1); finish_op(0, 1'b0);
        run_op(16'h0000, 16'h0000, 4'b1001, 1'b0, 1'b1, -1); finish_op(0, 1'b0);

        // Logic mode: carry-in must not leak into result or cout.
        run_op(16'hF0F0, 16'hFF00, 4'b1011, 1'b1, 1'b1, -1); finish_op(0, 1'b0);

        // Backpressure with an ignored request during DONE.
        run_op(16'hABCD, 16'h4321, 4'b1001, 1'b0, 1'b1, -1); finish_op(5, 1'b1);

        // out_ready held high through IDLE and RUN.
        out_ready = 1'b1;
        run_op(16'h00FF, 16'h0F0F, 4'b1001, 1'b1, 1'b0, -1); finish_op(0, 1'b0);

        // Reset mid-add at bit 7, then a clean op.
        run_op(16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b0, 7);
        run_op(16'h0003, 16'h0005, 4'b1001, 1'b0, 1'b0, -1); finish_op(0, 1'b0);

        // A few random adds.
        for (int i = 0; i < 4; i++) begin
            run_op(W'($urandom), W'($urandom), 4'b1001, 1'b0, 1'($urandom), -1);
            finish_op(i, 1'b0);
        end

        chk("sb_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
